// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply.
// Results and status flags are registered and held until the next completion.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       codop,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] operando2,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] resultado,
  output logic             neg,
  output logic             zero,
  output logic             overflow,
  output logic             carry
);

  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_GTU  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_ORI  = 4'd7;
  localparam logic [3:0] OP_XORI = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_SUBI = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;
  localparam logic [3:0] OP_SAR  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [SHW-1:0]   cnt_q;

  logic             accept_c;
  logic             mul_done_c;
  logic [AW-1:0]    mul_sum_c;

  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c;
  logic             alu_cry_c;
  logic [WIDTH:0]   ext_c;
  logic [SHW-1:0]   sh_c;
  logic [AW-1:0]    shl_c;
  logic [AW-1:0]    shr_c;
  logic signed [AW-1:0] sar_c;

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign accept_c   = in_valid && (state_q == IDLE);
  assign mul_done_c = (state_q == MUL) && (cnt_q == SHW'(WIDTH - 1));
  assign mul_sum_c  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Shifts done in a double-width window so the last bit shifted out lands at a fixed index.
  always_comb begin
    sh_c  = operando2[SHW-1:0];
    shl_c = {{WIDTH{1'b0}}, operando1} << sh_c;
    shr_c = {operando1, {WIDTH{1'b0}}} >> sh_c;
    sar_c = $signed({operando1, {WIDTH{1'b0}}}) >>> sh_c;
  end

  // Single-cycle result and flags; multiply and illegal codes fall to zero here.
  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    alu_cry_c = 1'b0;
    ext_c     = '0;
    case (codop)
      OP_ADD: begin
        ext_c     = {1'b0, operando1} + {1'b0, operando2};
        alu_res_c = ext_c[WIDTH-1:0];
        alu_cry_c = ext_c[WIDTH];
        alu_ovf_c = add_ovf(operando1, operando2, alu_res_c);
      end
      OP_SUB: begin
        alu_res_c = operando1 - operando2;
        alu_cry_c = operando1 < operando2;
        alu_ovf_c = sub_ovf(operando1, operando2, alu_res_c);
      end
      OP_GTU:  alu_res_c = (operando1 > operando2) ? WIDTH'(1) : '0;
      OP_AND:  alu_res_c = operando1 & operando2;
      OP_OR:   alu_res_c = operando1 | operando2;
      OP_XOR:  alu_res_c = operando1 ^ operando2;
      OP_ANDI: alu_res_c = imm & operando2;
      OP_ORI:  alu_res_c = imm | operando2;
      OP_XORI: alu_res_c = imm ^ operando2;
      OP_ADDI: begin
        ext_c     = {1'b0, imm} + {1'b0, operando2};
        alu_res_c = ext_c[WIDTH-1:0];
        alu_cry_c = ext_c[WIDTH];
        alu_ovf_c = add_ovf(imm, operando2, alu_res_c);
      end
      OP_SUBI: begin
        alu_res_c = operando2 - imm;
        alu_cry_c = operando2 < imm;
        alu_ovf_c = sub_ovf(operando2, imm, alu_res_c);
      end
      OP_SHL: begin
        alu_res_c = shl_c[WIDTH-1:0];
        alu_cry_c = shl_c[WIDTH];
      end
      OP_SHR: begin
        alu_res_c = shr_c[AW-1:WIDTH];
        alu_cry_c = shr_c[WIDTH-1];
      end
      OP_SAR: begin
        alu_res_c = sar_c[AW-1:WIDTH];
        alu_cry_c = sar_c[WIDTH-1];
      end
      default: begin
        alu_res_c = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c && (codop == OP_MUL)) state_d = MUL;
      MUL:     if (mul_done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, one multiplier bit per MUL cycle, register completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      resultado <= '0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      out_valid <= 1'b0;
      in_ready  <= (state_d == IDLE);
      if (accept_c) begin
        if (codop == OP_MUL) begin
          acc_q    <= '0;
          mcand_q  <= AW'(operando1);
          mplier_q <= operando2;
          cnt_q    <= '0;
        end else begin
          resultado <= alu_res_c;
          neg       <= alu_res_c[WIDTH-1];
          zero      <= (alu_res_c == '0);
          overflow  <= alu_ovf_c;
          carry     <= alu_cry_c;
          out_valid <= 1'b1;
        end
      end else if (state_q == MUL) begin
        acc_q    <= mul_sum_c;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
        if (mul_done_c) begin
          resultado <= mul_sum_c[WIDTH-1:0];
          neg       <= mul_sum_c[WIDTH-1];
          zero      <= (mul_sum_c[WIDTH-1:0] == '0);
          overflow  <= |mul_sum_c[AW-1:WIDTH];
          carry     <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 with hand-computed expectations.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  codop;
  logic [15:0] operando1, operando2, imm;
  logic        out_valid;
  logic [15:0] resultado;
  logic        neg, zero, overflow, carry;

  int vectors = 0;
  int errors  = 0;

  alu_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codop(codop), .operando1(operando1), .operando2(operando2), .imm(imm),
    .out_valid(out_valid), .resultado(resultado),
    .neg(neg), .zero(zero), .overflow(overflow), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic n,
                         input logic z, input logic o, input logic c);
    chk1({tag, " out_valid"}, out_valid, 1'b1);
    chk16({tag, " resultado"}, resultado, r);
    chk1({tag, " neg"}, neg, n);
    chk1({tag, " zero"}, zero, z);
    chk1({tag, " overflow"}, overflow, o);
    chk1({tag, " carry"}, carry, c);
  endtask

  // Present one request for exactly one rising edge; returns 1 time unit after that edge.
  task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] i);
    @(negedge clk);
    in_valid = 1'b1; codop = c; operando1 = a; operando2 = b; imm = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic n, input logic z, input logic o);
    logic [15:0] cyc;
    logic [15:0] ready_low;
    cyc = 16'd0;
    ready_low = 16'd0;
    issue(4'd14, a, b, 16'h0000);
    while (!out_valid && cyc < 16'd40) begin
      if (!in_ready) ready_low = ready_low + 16'd1;
      if (cyc == 16'd3 || cyc == 16'd8) begin
        in_valid = 1'b1; codop = 4'd0; operando1 = 16'h1111; operando2 = 16'h2222;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc = cyc + 16'd1;
    end
    in_valid = 1'b0;
    chk16({tag, " latency"}, cyc, 16'd16);
    chk16({tag, " busy cycles"}, ready_low, 16'd16);
    chk1({tag, " ready after"}, in_ready, 1'b1);
    chk_out(tag, r, n, z, o, 1'b0);
    @(posedge clk);
    #1;
    chk1({tag, " ignored req no result"}, out_valid, 1'b0);
    chk16({tag, " held"}, resultado, r);
  endtask

  initial begin
    logic [15:0] pulses;
    rst = 1'b1; in_valid = 1'b0; codop = 4'd0;
    operando1 = 16'h0; operando2 = 16'h0; imm = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset out_valid", out_valid, 1'b0);
    chk16("reset resultado", resultado, 16'h0000);
    chk16("reset flags", {12'h000, neg, zero, overflow, carry}, 16'h0000);
    chk1("reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    issue(4'd0, 16'h7FFF, 16'h0001, 16'h0000); chk_out("add ovf", 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(4'd1, 16'h0000, 16'h0001, 16'h0000); chk_out("sub borrow", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'd5, 16'h1234, 16'h1234, 16'h0000); chk_out("xor zero", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'd0, 16'hFFFF, 16'h0002, 16'h0000); chk_out("add carry", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk1("idle out_valid", out_valid, 1'b0);
    chk16("idle hold resultado", resultado, 16'h0001);
    chk1("idle hold carry", carry, 1'b1);

    issue(4'd13, 16'h8001, 16'h0001, 16'h0000); chk_out("sar", 16'hC000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'd12, 16'h8001, 16'h0001, 16'h0000); chk_out("shr", 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd11, 16'h8001, 16'h0001, 16'h0000); chk_out("shl", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd11, 16'h8001, 16'h0010, 16'h0000); chk_out("shl sh0", 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'd2, 16'hFFFF, 16'h0001, 16'h0000); chk_out("gtu true", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd2, 16'h0003, 16'h0005, 16'h0000); chk_out("gtu false", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'd6, 16'h0000, 16'hFF00, 16'hF0F0); chk_out("andi", 16'hF000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'd10, 16'h0000, 16'h8000, 16'h0001); chk_out("subi ovf", 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'd15, 16'hFFFF, 16'hFFFF, 16'hFFFF); chk_out("illegal", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

    do_mul("mul 0100", 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b1);
    do_mul("mul small", 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0);
    do_mul("mul max", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);

    // Abort a multiply with an asynchronous reset asserted mid-cycle.
    issue(4'd14, 16'h0100, 16'h0003, 16'h0000);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk1("abort out_valid", out_valid, 1'b0);
    chk16("abort resultado", resultado, 16'h0000);
    chk16("abort flags", {12'h000, neg, zero, overflow, carry}, 16'h0000);
    chk1("abort in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; codop = 4'd9; operando1 = 16'h0000; operando2 = 16'h0001; imm = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("addi after reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    pulses = 16'd0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses = pulses + 16'd1;
    end
    chk16("aborted mul no pulse", pulses, 16'd0);
    chk16("post abort held", resultado, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
